// File: rtl/alu_signext_unit.sv
// rtl/alu_signext_unit.sv - registered 8-bit add/subtract execute stage with immediate sign extension
// One-cycle latency: operand mux, ALU and flags are combinational, all outputs come from one register stage.

module SignExt_3to8 (
    input  logic [2:0] a,
    output logic [7:0] out
);
    assign out = {{5{a[2]}}, a};
endmodule

module SignExt_5to8 (
    input  logic [4:0] a,
    output logic [7:0] out
);
    assign out = {{3{a[4]}}, a};
endmodule

module ALU (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       op,
    output logic [7:0] out
);
    logic [7:0] b_eff;

    // Subtract is a + ~b + 1 so add and subtract share one adder.
    assign b_eff = op ? ~b : b;
    assign out   = a + b_eff + {7'd0, op};
endmodule

module alu_signext_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] imm3,
    input  logic [4:0] imm5,
    input  logic [1:0] bsel,
    input  logic       op,
    output logic [7:0] result,
    output logic [7:0] ext3,
    output logic [7:0] ext5,
    output logic       zero,
    output logic       negative,
    output logic       carry,
    output logic       overflow,
    output logic       out_valid
);
    logic [7:0] ext3_d, ext5_d, opb, alu_out, x;
    logic [8:0] sum;
    logic       zero_d, negative_d, carry_d, overflow_d;

    logic [7:0] result_q, ext3_q, ext5_q;
    logic       zero_q, negative_q, carry_q, overflow_q, out_valid_q;

    SignExt_3to8 u_sext3 (.a(imm3), .out(ext3_d));
    SignExt_5to8 u_sext5 (.a(imm5), .out(ext5_d));

    always_comb begin
        opb = b;
        case (bsel)
            2'b01:   opb = ext3_d;
            2'b10:   opb = ext5_d;
            default: opb = b;
        endcase
    end

    ALU u_alu (.a(a), .b(opb), .op(op), .out(alu_out));

    // Flags come from the 9-bit sum; for subtract carry out means "no borrow".
    assign x          = op ? ~opb : opb;
    assign sum        = {1'b0, a} + {1'b0, x} + {8'd0, op};
    assign zero_d     = (alu_out == 8'd0);
    assign negative_d = alu_out[7];
    assign carry_d    = sum[8];
    assign overflow_d = (a[7] == x[7]) && (alu_out[7] != a[7]);

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q    <= 8'd0;
            ext3_q      <= 8'd0;
            ext5_q      <= 8'd0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                result_q   <= alu_out;
                ext3_q     <= ext3_d;
                ext5_q     <= ext5_d;
                zero_q     <= zero_d;
                negative_q <= negative_d;
                carry_q    <= carry_d;
                overflow_q <= overflow_d;
            end
        end
    end

    assign result    = result_q;
    assign ext3      = ext3_q;
    assign ext5      = ext5_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_signext_unit.sv
// tb/tb_alu_signext_unit.sv - self-checking bench for alu_signext_unit against an arithmetic reference model

module tb_alu_signext_unit;
    logic       clk = 1'b0;
    logic       reset, in_valid, op;
    logic [7:0] a, b;
    logic [2:0] imm3;
    logic [4:0] imm5;
    logic [1:0] bsel;
    logic [7:0] result, ext3, ext5;
    logic       zero, negative, carry, overflow, out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] er, e3, e5;
    logic       ez, en, ec, ev;

    alu_signext_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
        .imm3(imm3), .imm5(imm5), .bsel(bsel), .op(op),
        .result(result), .ext3(ext3), .ext5(ext5), .zero(zero),
        .negative(negative), .carry(carry), .overflow(overflow),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Reference: signed/unsigned integer arithmetic straight from the operation rules.
    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] mi3,
                         input logic [4:0] mi5, input logic [1:0] ms, input logic mop);
        int s3, s5, ub, sa, sb, ures, sres;
        s3 = (int'(mi3) >= 4)  ? int'(mi3) - 8  : int'(mi3);
        s5 = (int'(mi5) >= 16) ? int'(mi5) - 32 : int'(mi5);
        if (ms == 2'b01)      ub = s3 & 255;
        else if (ms == 2'b10) ub = s5 & 255;
        else                  ub = int'(mb);
        sa   = (int'(ma) >= 128) ? int'(ma) - 256 : int'(ma);
        sb   = (ub >= 128) ? ub - 256 : ub;
        ures = mop ? int'(ma) - ub : int'(ma) + ub;
        sres = mop ? sa - sb : sa + sb;
        er = 8'(ures & 255);
        e3 = 8'(s3 & 255);
        e5 = 8'(s5 & 255);
        ez = ((ures & 255) == 0);
        en = ((ures & 255) >= 128);
        ec = mop ? (int'(ma) >= ub) : (ures > 255);
        ev = (sres > 127) || (sres < -128);
    endtask

    task automatic drive(input logic rst, input logic vld, input logic [7:0] da, input logic [7:0] db,
                         input logic [2:0] di3, input logic [4:0] di5, input logic [1:0] ds, input logic dop);
        reset = rst; in_valid = vld; a = da; b = db; imm3 = di3; imm5 = di5; bsel = ds; op = dop;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++)
            drive(1'b1, 1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 5'($urandom), 2'($urandom), 1'($urandom));
        n_checks++;
        if ({result, ext3, ext5, zero, negative, carry, overflow, out_valid} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {result, ext3, ext5, zero, negative, carry, overflow, out_valid});
        end
        model(8'h33, 8'h11, 3'b010, 5'b00011, 2'b00, 1'b0);
        drive(1'b0, 1'b1, 8'h33, 8'h11, 3'b010, 5'b00011, 2'b00, 1'b0);
        n_checks++;
        if ({result, ext3, ext5, out_valid} !== {er, e3, e5, 1'b1} || result !== 8'h44) begin
            n_fail++;
            $display("FAIL first_after_reset: got r=%h e3=%h e5=%h v=%b required r=44 e3=%h e5=%h v=1",
                     result, ext3, ext5, out_valid, e3, e5);
        end
    endtask

    task automatic test_ext3();
        logic [2:0] vin [4] = '{3'b001, 3'b000, 3'b100, 3'b111};
        logic [7:0] vexp[4] = '{8'h01, 8'h00, 8'hFC, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'h10, 8'h20, vin[i], 5'd0, 2'b01, 1'b0);
            n_checks++;
            if (ext3 !== vexp[i] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL ext3[%0d]: got %h v=%b required %h v=1", i, ext3, out_valid, vexp[i]);
            end
        end
    endtask

    task automatic test_ext5();
        logic [4:0] vin [4] = '{5'b00000, 5'b01110, 5'b10110, 5'b11111};
        logic [7:0] vexp[4] = '{8'h00, 8'h0E, 8'hF6, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'h10, 8'h20, 3'd0, vin[i], 2'b10, 1'b1);
            n_checks++;
            if (ext5 !== vexp[i]) begin
                n_fail++;
                $display("FAIL ext5[%0d]: got %h required %h", i, ext5, vexp[i]);
            end
        end
    endtask

    // Each row: a, b, op, result, zero, negative, carry, overflow.
    task automatic test_arith();
        logic [7:0] ta[6] = '{8'h6D, 8'h21, 8'h80, 8'h7D, 8'h01, 8'hFF};
        logic [7:0] tb[6] = '{8'h0C, 8'h04, 8'h01, 8'h6C, 8'h00, 8'h01};
        logic       to[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] tr[6] = '{8'h61, 8'h1D, 8'h7F, 8'hE9, 8'h01, 8'h00};
        logic [3:0] tf[6] = '{4'b0010, 4'b0010, 4'b0011, 4'b0101, 4'b0000, 4'b1010};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, ta[i], tb[i], 3'($urandom), 5'($urandom), 2'b00, to[i]);
            n_checks++;
            if (result !== tr[i] || {zero, negative, carry, overflow} !== tf[i]) begin
                n_fail++;
                $display("FAIL arith[%0d]: got r=%h znco=%b required r=%h znco=%b",
                         i, result, {zero, negative, carry, overflow}, tr[i], tf[i]);
            end
        end
    endtask

    task automatic test_imm_hold();
        drive(1'b0, 1'b1, 8'h05, 8'hAA, 3'b111, 5'b00000, 2'b01, 1'b0);
        n_checks++;
        if (result !== 8'h04 || carry !== 1'b1) begin
            n_fail++;
            $display("FAIL imm3_add: got r=%h c=%b required r=04 c=1", result, carry);
        end
        model(8'h05, 8'hAA, 3'b000, 5'b10110, 2'b10, 1'b1);
        drive(1'b0, 1'b1, 8'h05, 8'hAA, 3'b000, 5'b10110, 2'b10, 1'b1);
        n_checks++;
        if (result !== 8'h0F || carry !== 1'b0 || ext5 !== 8'hF6) begin
            n_fail++;
            $display("FAIL imm5_sub: got r=%h c=%b e5=%h required r=0F c=0 e5=F6", result, carry, ext5);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 8'($urandom), 8'($urandom), 3'($urandom), 5'($urandom), 2'($urandom), 1'($urandom));
            n_checks++;
            if ({result, ext3, ext5, zero, negative, carry, overflow, out_valid} !==
                {er, e3, e5, ez, en, ec, ev, 1'b0}) begin
                n_fail++;
                $display("FAIL hold[%0d]: got %h required %h", i,
                         {result, ext3, ext5, zero, negative, carry, overflow, out_valid},
                         {er, e3, e5, ez, en, ec, ev, 1'b0});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ra, rb;
        logic [2:0] ri3;
        logic [4:0] ri5;
        logic [1:0] rs;
        logic       rop, rv;
        logic [7:0] hr, h3, h5;
        logic       hz, hn, hc, hv;
        model(8'h05, 8'hAA, 3'b000, 5'b10110, 2'b10, 1'b1);
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); ri3 = 3'($urandom); ri5 = 5'($urandom);
            rs = 2'($urandom); rop = 1'($urandom); rv = ($urandom_range(0, 3) != 0);
            hr = er; h3 = e3; h5 = e5; hz = ez; hn = en; hc = ec; hv = ev;
            if (rv) model(ra, rb, ri3, ri5, rs, rop);
            else begin
                er = hr; e3 = h3; e5 = h5; ez = hz; en = hn; ec = hc; ev = hv;
            end
            drive(1'b0, rv, ra, rb, ri3, ri5, rs, rop);
            n_checks++;
            if ({result, ext3, ext5, zero, negative, carry, overflow, out_valid} !==
                {er, e3, e5, ez, en, ec, ev, rv}) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h required %h (a=%h b=%h i3=%b i5=%b s=%b op=%b v=%b)", i,
                         {result, ext3, ext5, zero, negative, carry, overflow, out_valid},
                         {er, e3, e5, ez, en, ec, ev, rv}, ra, rb, ri3, ri5, rs, rop, rv);
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = 8'd0; b = 8'd0;
        imm3 = 3'd0; imm5 = 5'd0; bsel = 2'd0; op = 1'b0;
        test_reset();
        test_ext3();
        test_ext5();
        test_arith();
        test_imm_hold();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_signext_unit.md
# alu_signext_unit

Registered 8-bit execute stage for the simple processor datapath, built from three combinational sub-blocks and one output register stage. `SignExt_3to8` and `SignExt_5to8` sign-extend instruction immediates to 8 bits. `ALU` performs 8-bit add or subtract. The unit selects the second ALU operand, computes the result and status flags, and registers everything with a one-cycle latency for the writeback stage.

## Interface
Parameters: none (all widths fixed).
- `clk`  input  1  single system clock; all state updates on the rising edge
- `reset`  input  1  synchronous, active-high reset
- `in_valid`  input  1  operands and controls on this cycle are to be captured
- `a`  input  8  first ALU operand (register value)
- `b`  input  8  second ALU operand (register value)
- `imm3`  input  3  3-bit two's-complement immediate
- `imm5`  input  5  5-bit two's-complement immediate
- `bsel`  input  2  second-operand select: 00 = `b`, 01 = sign-extended `imm3`, 10 = sign-extended `imm5`, 11 = `b`
- `op`  input  1  ALU operation: 0 = add, 1 = subtract
- `result`  output  8  registered ALU result
- `ext3`  output  8  registered sign-extension of `imm3`
- `ext5`  output  8  registered sign-extension of `imm5`
- `zero`, `negative`, `carry`, `overflow`  output  1 each  registered status flags
- `out_valid`  output  1  registered outputs were updated on the last edge

## Operation
- **`SignExt_3to8`**
  - `out[2:0] = a[2:0]`; `out[7:3]` = five copies of `a[2]`.
  - Purely combinational.
- **`SignExt_5to8`**
  - `out[4:0] = a[4:0]`; `out[7:5]` = three copies of `a[4]`.
  - Purely combinational.
- **`ALU`** (ports `a`, `b`, `op`, `out`; purely combinational)
  - op = 0: out = (a + b) mod 256.
  - op = 1: out = (a − b) mod 256, computed as a + ~b + 1.
- **Operand mux:** `opb` is chosen by `bsel` as listed above.
- **Flags**, computed from the 9-bit sum s = {0,a} + {0,x} + cin, where x = `opb`, cin = 0 for add; x = ~`opb`, cin = 1 for subtract:
  - zero = (s[7:0] == 0)
  - negative = s[7]
  - carry = s[8]. For subtract this means "no borrow", i.e. 1 when a ≥ opb unsigned.
  - overflow = signed overflow: for add, operands share a sign and the result sign differs; for subtract, operands differ in sign and the result sign differs from `a`.
- **Register stage:**
  - When `in_valid` = 1, `result`, flags, `ext3` and `ext5` capture the combinational values.
  - When `in_valid` = 0, all data outputs and flags hold their previous values.
- Sign extension is always applied regardless of `op`; the `ext3`/`ext5` outputs reflect the immediates captured with the last valid input.

## Timing
- Latency is exactly 1 cycle: inputs sampled at edge N appear on outputs after edge N and remain stable until the next captured transaction.
- `out_valid` at edge N+1 equals `in_valid` sampled at edge N.
- `out_valid` is 0 on cycles with no capture; data outputs hold while it is 0.
- Back-to-back `in_valid` = 1 gives one result per cycle. There is no backpressure and no stall.
- **Reset:** on a rising edge with `reset` = 1, all outputs (`result`, `ext3`, `ext5`, all flags, `out_valid`) become 0.
  - Reset has priority over `in_valid` on the same edge.
  - A transaction presented on a reset edge is discarded.
- Reset deasserted mid-stream: the first capture occurs on the first edge where `reset` = 0 and `in_valid` = 1.
- Carry and overflow wrap rules:
  - results are always truncated to 8 bits;
  - 0xFF + 0x01 = 0x00 with carry = 1, zero = 1;
  - 0x80 − 0x01 = 0x7F with overflow = 1.

## Test plan
- **Reset:** hold `reset` high for 2 cycles with `in_valid` = 1 → every output is 0 and `out_valid` = 0. Release reset → the next valid input appears one cycle later.
- **3-bit extension:** `imm3` = 001, 000, 100, 111 → `ext3` = 0x01, 0x00, 0xFC, 0xFF.
- **5-bit extension:** `imm5` = 00000, 01110, 10110, 11111 → `ext5` = 0x00, 0x0E, 0xF6, 0xFF.
- **Subtract** (op = 1, `bsel` = 00):
  - 0x6D − 0x0C → `result` 0x61, carry 1, overflow 0.
  - 0x21 − 0x04 → 0x1D.
  - 0x80 − 0x01 → 0x7F, overflow 1.
- **Add** (op = 0, `bsel` = 00):
  - 0x7D + 0x6C → 0xE9, negative 1, overflow 1, carry 0.
  - 0x01 + 0x00 → 0x01.
  - 0xFF + 0x01 → 0x00, zero 1, carry 1.
- **Immediate path and hold:**
  - a = 0x05, `imm3` = 111, `bsel` = 01, op = 0 → 0x04, carry 1.
  - a = 0x05, `imm5` = 10110, `bsel` = 10, op = 1 → 0x0F.
  - Then drop `in_valid` for 3 cycles → outputs unchanged, `out_valid` = 0.
